// File: rtl/tt_um_array_divider_hhrb98.sv
// Sequential 8-by-4 unsigned restoring divider tile: one quotient bit per clock,
// with a start/busy/done handshake and an error flag for divide-by-zero or quotient overflow.
module tt_um_array_divider_hhrb98 #(
    parameter int N = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state;
    logic [N:0]     rem;
    logic [N-1:0]   sh;
    logic [N-1:0]   div;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   q_r;
    logic [N-1:0]   r_r;
    logic           err_r;

    logic [2*N-1:0] d_in;
    logic [N-1:0]   v_in;
    logic           start;
    logic [N:0]     t;
    logic           ge;
    logic [N:0]     rem_nxt;
    logic [N-1:0]   sh_nxt;

    assign d_in  = ui_in[2*N-1:0];
    assign v_in  = uio_in[N-1:0];
    assign start = uio_in[N];

    // rem[N] is always 0 between steps (rem < V), so only the low bits feed the next trial.
    logic unused;
    assign unused = &{1'b0, uio_in[7:5], rem[N]};

    always_comb begin
        t       = {rem[N-1:0], sh[N-1]};
        ge      = (t >= {1'b0, div});
        rem_nxt = ge ? (t - {1'b0, div}) : t;
        sh_nxt  = {sh[N-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            rem   <= '0;
            sh    <= '0;
            div   <= '0;
            cnt   <= '0;
            q_r   <= '0;
            r_r   <= '0;
            err_r <= 1'b0;
        end else if (ena) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        div   <= v_in;
                        err_r <= 1'b0;
                        if (v_in == '0) begin
                            q_r   <= '1;
                            r_r   <= '0;
                            err_r <= 1'b1;
                            state <= S_DONE;
                        end else if (d_in[2*N-1:N] >= v_in) begin
                            // quotient would not fit in N bits
                            q_r   <= '1;
                            r_r   <= '1;
                            err_r <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            rem   <= {1'b0, d_in[2*N-1:N]};
                            sh    <= d_in[N-1:0];
                            cnt   <= '0;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem <= rem_nxt;
                    sh  <= sh_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        q_r   <= sh_nxt;
                        r_r   <= rem_nxt[N-1:0];
                        err_r <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!start) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign uo_out  = {r_r, q_r};
    assign uio_out = {err_r, state == S_DONE, state == S_RUN, 5'b0_0000};
    assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_array_divider_hhrb98.sv
// Self-checking bench for the divider tile: directed cases, a product sweep and random
// operands, all scored against a plain-arithmetic quotient/remainder model.
module tb_tt_um_array_divider_hhrb98;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int failures = 0;

    tt_um_array_divider_hhrb98 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {err, R, Q} from plain integer division.
    function automatic logic [8:0] model(input logic [7:0] d, input logic [3:0] v);
        int q;
        if (v == 4'd0) return {1'b1, 4'h0, 4'hF};
        q = int'(d) / int'(v);
        if (q > 15) return {1'b1, 4'hF, 4'hF};
        return {1'b0, 4'(int'(d) % int'(v)), 4'(q)};
    endfunction

    task automatic run_op(input logic [7:0] d, input logic [3:0] v, input bit hold, input bit gap);
        logic [8:0] m;
        int lat;
        int exp_lat;
        logic [7:0] snap_o;
        logic [7:0] snap_u;
        m = model(d, v);
        exp_lat = m[8] ? 1 : (gap ? 8 : 5);
        @(negedge clk);
        ui_in  = d;
        uio_in = {3'b000, 1'b1, v};
        @(negedge clk);
        lat = 1;
        // scramble operands after capture; start stays high only when holding
        ui_in  = 8'($urandom);
        uio_in = {3'($urandom), hold, 4'($urandom)};
        chk("busy_after_capture", {31'd0, uio_out[5]}, {31'd0, !m[8]});
        while (!uio_out[6] && lat < 40) begin
            chk("busy_done_exclusive", {30'd0, uio_out[6:5]} == 32'd3, 32'd0);
            if (gap && lat == 2) begin
                snap_o = uo_out;
                snap_u = uio_out;
                ena = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    lat++;
                    chk("frozen_uo", {24'd0, uo_out}, {24'd0, snap_o});
                    chk("frozen_uio", {24'd0, uio_out}, {24'd0, snap_u});
                end
                ena = 1'b1;
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("result_rq", {24'd0, uo_out}, {24'd0, m[7:0]});
        chk("err", {31'd0, uio_out[7]}, {31'd0, m[8]});
        chk("done_flags", {30'd0, uio_out[6:5]}, 32'd2);
        if (hold) begin
            repeat (5) @(negedge clk);
            chk("hold_done", {30'd0, uio_out[6:5]}, 32'd2);
            chk("hold_result", {24'd0, uo_out}, {24'd0, m[7:0]});
            uio_in[4] = 1'b0;
        end
        @(negedge clk);
        chk("idle_flags", {30'd0, uio_out[6:5]}, 32'd0);
        chk("held_result", {24'd0, uo_out}, {24'd0, m[7:0]});
        chk("held_err", {31'd0, uio_out[7]}, {31'd0, m[8]});
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_uo", {24'd0, uo_out}, 32'd0);
        chk("reset_uio", {24'd0, uio_out}, 32'd0);
        chk("uio_oe", {24'd0, uio_oe}, 32'hE0);
        rst_n = 1'b1;

        run_op(8'h64, 4'd7, 1'b0, 1'b0);
        run_op(8'hC3, 4'd13, 1'b0, 1'b0);
        run_op(8'h55, 4'd0, 1'b0, 1'b0);
        run_op(8'hF0, 4'd15, 1'b0, 1'b0);
        run_op(8'h20, 4'd3, 1'b0, 1'b0);
        run_op(8'h64, 4'd7, 1'b1, 1'b0);
        run_op(8'h12, 4'd5, 1'b0, 1'b0);

        // reset during the second RUN cycle aborts the operation
        @(negedge clk);
        ui_in  = 8'h64;
        uio_in = 8'h17;
        @(negedge clk);
        uio_in = 8'h07;
        @(negedge clk);
        chk("run_before_reset", {31'd0, uio_out[5]}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_uo", {24'd0, uo_out}, 32'd0);
        chk("abort_uio", {24'd0, uio_out}, 32'd0);
        rst_n  = 1'b1;
        uio_in = 8'h00;
        @(negedge clk);
        chk("abort_stays_idle", {24'd0, uio_out}, 32'd0);

        run_op(8'h2A, 4'd6, 1'b0, 1'b0);
        run_op(8'h64, 4'd7, 1'b0, 1'b1);

        for (int a = 1; a < 16; a++)
            for (int b = 1; b < 16; b++)
                run_op(8'(a * b), 4'(b), 1'b0, 1'b0);

        for (int i = 0; i < 40; i++)
            run_op(8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
